// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: button channel count, channel
// indices and the per-channel debounce state encoding.
package alu_pkg;

  localparam int NB_INPUT_SELECT = 3;

  localparam int DATA_A  = 0;
  localparam int DATA_B  = 1;
  localparam int OP_CODE = 2;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_HIGH,
    DB_HIGH,
    DB_WAIT_LOW
  } db_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability counter,
// registered level and press strobe. BTN_CONDITIONER_RELEASE_PULSE_EN adds a release strobe.
module btn_debounce_ch
  import alu_pkg::*;
#(
  parameter int N_DEBOUNCE = 4
) (
  input  logic clock,
  input  logic i_rst,
  input  logic btn,
  output logic level,
  output logic pulse
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
  ,
  output logic fall
`endif
);

  localparam int CNT_W = $clog2(N_DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DEBOUNCE - 1);

  logic            sync_p0;
  logic            sync_p1;
  db_state_e       state;
  logic [CNT_W-1:0] cnt;

  // The counter is only examined in the WAIT states and cleared on every exit,
  // so it can never wrap.
  always_ff @(posedge clock or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= DB_IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
      fall    <= 1'b0;
`endif
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      pulse   <= 1'b0;
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
      fall    <= 1'b0;
`endif
      case (state)
        DB_IDLE: begin
          if (sync_p1) begin
            state <= DB_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        DB_WAIT_HIGH: begin
          if (!sync_p1) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_HIGH: begin
          if (!sync_p1) begin
            state <= DB_WAIT_LOW;
            cnt   <= '0;
          end
        end
        DB_WAIT_LOW: begin
          if (sync_p1) begin
            state <= DB_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
            level <= 1'b0;
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
            fall  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the DATA_A / DATA_B / OP_CODE push buttons into clean levels and
// one-cycle press strobes. BTN_CONDITIONER_RELEASE_PULSE_EN adds o_btn_release.
module btn_conditioner #(
  parameter int NB_INPUT_SELECT = alu_pkg::NB_INPUT_SELECT,
  parameter int N_DEBOUNCE      = 4
) (
  input  logic                       clock,
  input  logic                       i_rst,
  input  logic [NB_INPUT_SELECT-1:0] i_btn,
  output logic [NB_INPUT_SELECT-1:0] o_btn_level,
  output logic [NB_INPUT_SELECT-1:0] o_btn_pulse
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
  ,
  output logic [NB_INPUT_SELECT-1:0] o_btn_release
`endif
);

  // Channels are fully independent; no priority between simultaneous presses.
  for (genvar k = 0; k < NB_INPUT_SELECT; k++) begin : g_ch
    btn_debounce_ch #(
      .N_DEBOUNCE(N_DEBOUNCE)
    ) u_ch (
      .clock (clock),
      .i_rst (i_rst),
      .btn   (i_btn[k]),
      .level (o_btn_level[k]),
      .pulse (o_btn_pulse[k])
`ifdef BTN_CONDITIONER_RELEASE_PULSE_EN
      ,
      .fall  (o_btn_release[k])
`endif
    );
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter NB_INPUT_SELECT, default 3, giving the number of button channels (bit 0 = DATA_A, bit 1 = DATA_B, bit 2 = OP_CODE).
REQ-002 The block SHALL have parameter N_DEBOUNCE, default 4, giving the number of consecutive stable synchronized cycles needed to accept a level change; legal range is 2 or more.
REQ-003 The block SHALL have input clock, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have input i_rst, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have input i_btn, NB_INPUT_SELECT bits: raw, asynchronous, bouncy push-button levels.
REQ-006 The block SHALL have output o_btn_level, NB_INPUT_SELECT bits: the debounced, registered button level per channel.
REQ-007 The block SHALL have output o_btn_pulse, NB_INPUT_SELECT bits: a one-cycle, registered press strobe per channel; this is the load strobe consumed by the ALU top.

Function
REQ-008 Each channel SHALL pass i_btn[k] through a 2-flop synchronizer; its output is called s[k].
REQ-009 Each channel SHALL run an independent FSM with states IDLE (stable low), WAIT_HIGH, HIGH (stable high) and WAIT_LOW, plus a counter of width $clog2(N_DEBOUNCE).
REQ-010 In IDLE with s=1, the FSM SHALL go to WAIT_HIGH and clear the counter; with s=0 it SHALL stay in IDLE.
REQ-011 In WAIT_HIGH, if s=1 and the counter is below N_DEBOUNCE-1, the counter SHALL increment; if s=1 and the counter equals N_DEBOUNCE-1, the FSM SHALL go to HIGH, set o_btn_level=1, and assert o_btn_pulse for one cycle; if s=0, the FSM SHALL return to IDLE with the counter cleared and no pulse.
REQ-012 HIGH and WAIT_LOW SHALL mirror REQ-010 and REQ-011 with the polarity inverted; on acceptance in WAIT_LOW the FSM SHALL clear o_btn_level and SHALL NOT pulse.
REQ-013 Latency SHALL be: o_btn_pulse is high during the cycle after the (N_DEBOUNCE+3)th rising edge, counting from the first edge that samples i_btn high; with the default N_DEBOUNCE this is 7 cycles.
REQ-014 o_btn_pulse SHALL be exactly one cycle per accepted press, no matter how long the button is held; a held button SHALL NOT re-pulse.
REQ-015 Any bounce, i.e. s reverting while in a WAIT state, SHALL abort the change and restart the count on the next transition; glitches shorter than N_DEBOUNCE synchronized cycles SHALL never change o_btn_level.
REQ-016 Channels SHALL be fully independent; simultaneous presses SHALL produce coincident pulses, and the block applies no priority.
REQ-017 The counter SHALL never wrap, because it is only compared while in a WAIT state and is cleared on every exit from one.

Reset
REQ-018 While i_rst=1, all synchronizer flops, counters, o_btn_level and o_btn_pulse SHALL be 0 and every FSM SHALL be in IDLE, asynchronously.
REQ-019 Reset asserted mid-count or mid-pulse SHALL discard the event; after release, a button already held SHALL be re-qualified from IDLE and SHALL pulse once.

Configuration
REQ-020 When macro BTN_CONDITIONER_RELEASE_PULSE_EN is defined, the block SHALL add output o_btn_release (NB_INPUT_SELECT bits), which pulses for one cycle on each accepted WAIT_LOW-to-IDLE transition, with latency symmetric to REQ-013.
REQ-021 When BTN_CONDITIONER_RELEASE_PULSE_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 The shared package alu_pkg SHALL hold NB_INPUT_SELECT, the button index constants DATA_A=0, DATA_B=1 and OP_CODE=2, and the debounce state enum.
REQ-023 The per-channel logic (synchronizer, FSM, counter, pulse) SHALL be a sub-module btn_debounce_ch, instantiated NB_INPUT_SELECT times by a generate loop.

Verification
REQ-024 The bench SHALL cover a clean press: i_btn=3'b001 for 10 cycles then 3'b000 -> o_btn_pulse=3'b001 for exactly one cycle, 7 cycles after the first sampled edge; o_btn_level[0] is high for 10 cycles.
REQ-025 The bench SHALL cover bounce rejection: i_btn[1] toggling 1,0,1,0 with a 2-cycle period, then held high for 10 cycles -> exactly one pulse on bit 1, issued N_DEBOUNCE+3 cycles after the final rise.
REQ-026 The bench SHALL cover a short glitch: i_btn[2]=1 for 3 cycles -> o_btn_level and o_btn_pulse stay 0.
REQ-027 The bench SHALL cover a simultaneous press: i_btn=3'b111 held for 10 cycles -> o_btn_pulse=3'b111 in a single cycle, then 3'b000.
REQ-028 The bench SHALL cover reset mid-press: i_rst pulsed at cycle 5 of a 20-cycle press on bit 0 -> outputs go to 0 immediately, and one pulse follows 7 cycles after reset release.
REQ-029 The bench SHALL cover release with BTN_CONDITIONER_RELEASE_PULSE_EN defined: release after a 10-cycle hold -> o_btn_release[0] pulses once, 7 cycles after the first sampled low.
